// File: rtl/hack_board_shell.sv
// Board shell for the Hack core on Basys3.
// Debounces the buttons, runs the core in HOLD/RUN/PAUSE modes, captures
// core writes into an LED register and drives the LEDs from a selectable source.
module hack_board_shell #(
  parameter int          DATA_W          = 16,
  parameter int          ADDR_W          = 15,
  parameter int unsigned LED_ADDR        = 'h6001,
  parameter int          DIV             = 100,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          START_RUN       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_reset,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic [1:0]        disp_sel,
  input  logic [DATA_W-1:0] outM,
  input  logic [ADDR_W-1:0] addressM,
  input  logic              writeM,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_ce,
  output logic              cpu_reset,
  output logic [DATA_W-1:0] leds
);

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic CE_ON_ENTRY = (DIV == 1);
  localparam logic [ADDR_W-1:0] LED_ADDR_C = ADDR_W'(LED_ADDR);

  // Button bit order: 0 = core reset, 1 = run/pause, 2 = single step
  logic [2:0]       btn_raw;
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [2:0]       deb;
  logic [2:1]       deb_q;
  logic [CNT_W-1:0] db_cnt [3];
  logic             run_rise;
  logic             step_rise;

  state_t           state;
  logic [DIV_W-1:0] divider;
  logic [DIV_W-1:0] div_next;
  logic [13:0]      instr_cnt;
  logic [DATA_W-1:0] led_reg;
  logic [DATA_W-1:0] last_wr;
  logic [15:0]      status;

  assign btn_raw   = {btn_step, btn_run, btn_reset};
  assign run_rise  = deb[1] & ~deb_q[1];
  assign step_rise = deb[2] & ~deb_q[2];
  assign div_next  = (divider == DIV_LAST) ? '0 : divider + 1'b1;
  assign status    = {state, instr_cnt};

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: accept a new level only after it has held for DEBOUNCE_CYCLES in a row
  always_ff @(posedge clk) begin
    if (reset) begin
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      deb_q <= deb[2:1];
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Run-control FSM with registered clock-enable and core reset
  always_ff @(posedge clk) begin
    if (reset || deb[0]) begin
      state     <= HOLD;
      divider   <= '0;
      cpu_ce    <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      case (state)
        HOLD: begin
          cpu_reset <= 1'b0;
          divider   <= '0;
          if (START_RUN != 0) begin
            state  <= RUN;
            cpu_ce <= CE_ON_ENTRY;
          end else begin
            state  <= PAUSE;
            cpu_ce <= 1'b0;
          end
        end
        RUN: begin
          if (run_rise) begin
            state   <= PAUSE;
            divider <= '0;
            cpu_ce  <= 1'b0;
          end else begin
            divider <= div_next;
            cpu_ce  <= (div_next == DIV_LAST);
          end
        end
        PAUSE: begin
          if (run_rise) begin
            state   <= RUN;
            divider <= '0;
            cpu_ce  <= CE_ON_ENTRY;
          end else begin
            cpu_ce <= step_rise;
          end
        end
        default: begin
          state     <= HOLD;
          divider   <= '0;
          cpu_ce    <= 1'b0;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

  // Capture core writes that happen on an enabled cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr <= '0;
      led_reg <= '0;
    end else if (cpu_ce && writeM) begin
      last_wr <= outM;
      if (addressM == LED_ADDR_C) led_reg <= outM;
    end
  end

  // Executed-instruction counter, cleared while the core is held in reset
  always_ff @(posedge clk) begin
    if (reset || state == HOLD) begin
      instr_cnt <= '0;
    end else if (cpu_ce) begin
      instr_cnt <= instr_cnt + 1'b1;
    end
  end

  // Registered LED source mux
  always_ff @(posedge clk) begin
    if (reset) begin
      leds <= '0;
    end else begin
      case (disp_sel)
        2'd0:    leds <= led_reg;
        2'd1:    leds <= DATA_W'(pc);
        2'd2:    leds <= last_wr;
        default: leds <= DATA_W'(status);
      endcase
    end
  end

endmodule

// File: tb/tb_hack_board_shell.sv
// Directed bench for hack_board_shell; cpu_ce pulses are checked against a
// queue of expected pulse cycles, other outputs against bench-computed values.
module tb_hack_board_shell;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_reset;
  logic        btn_run;
  logic        btn_step;
  logic [1:0]  disp_sel;
  logic [15:0] outM;
  logic [14:0] addressM;
  logic        writeM;
  logic [14:0] pc;
  logic        cpu_ce;
  logic        cpu_reset;
  logic [15:0] leds;

  logic [1:0]  disp_sel1 = 2'd3;
  logic        idle_btn = 1'b0;
  logic [15:0] idle_data = 16'h0000;
  logic [14:0] idle_addr = 15'h0000;
  logic        cpu_ce1;
  logic        cpu_reset1;
  logic [15:0] leds1;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int ce_seen = 0;
  int exp_ce_q[$];

  int c;
  int s;
  int b;
  int d;
  int e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  hack_board_shell #(
    .DATA_W(16), .ADDR_W(15), .LED_ADDR('h6001),
    .DIV(5), .DEBOUNCE_CYCLES(4), .START_RUN(0)
  ) dut (
    .clk(clk), .reset(reset), .btn_reset(btn_reset), .btn_run(btn_run),
    .btn_step(btn_step), .disp_sel(disp_sel), .outM(outM), .addressM(addressM),
    .writeM(writeM), .pc(pc), .cpu_ce(cpu_ce), .cpu_reset(cpu_reset), .leds(leds)
  );

  // Second instance: enable every cycle, starts running, used for the counter wrap
  hack_board_shell #(
    .DATA_W(16), .ADDR_W(15), .LED_ADDR('h6001),
    .DIV(1), .DEBOUNCE_CYCLES(4), .START_RUN(1)
  ) dut1 (
    .clk(clk), .reset(reset), .btn_reset(idle_btn), .btn_run(idle_btn),
    .btn_step(idle_btn), .disp_sel(disp_sel1), .outM(idle_data), .addressM(idle_addr),
    .writeM(idle_btn), .pc(idle_addr), .cpu_ce(cpu_ce1), .cpu_reset(cpu_reset1), .leds(leds1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_b, input logic run_b, input logic step_b);
    btn_reset = rst_b;
    btn_run   = run_b;
    btn_step  = step_b;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushPulses(input int first, input int last_allowed, input int period);
    for (int t = first; t <= last_allowed; t += period) exp_ce_q.push_back(t);
  endtask

  // Scoreboard: every cpu_ce pulse must match the next expected pulse cycle
  always @(negedge clk) begin : ce_monitor
    int exp_cyc;
    if (cpu_ce === 1'b1) begin
      ce_seen++;
      if (exp_ce_q.size() == 0) begin
        checkOutput("unexpected_ce", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_cyc = exp_ce_q.pop_front();
        checkOutput("ce_cycle", 32'(cyc), 32'(exp_cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    disp_sel = 2'd3;
    outM     = 16'h0000;
    addressM = 15'h0000;
    writeM   = 1'b0;
    pc       = 15'h5234;

    // Reset release and idle PAUSE
    waitUntil(4);
    reset = 1'b0;
    checkOutput("cpu_reset_during_reset", 32'(cpu_reset), 32'd1);
    checkOutput("cpu_ce_during_reset", 32'(cpu_ce), 32'd0);
    checkOutput("leds_reset", 32'(leds), 32'h0000);
    waitUntil(5);
    checkOutput("cpu_reset_released", 32'(cpu_reset), 32'd0);
    waitUntil(6);
    checkOutput("status_pause", 32'(leds), 32'h8000);
    checkOutput("dut1_first_status", 32'(leds1), 32'h4000);
    checkOutput("dut1_ce_every_cycle", 32'(cpu_ce1), 32'd1);
    checkOutput("dut1_cpu_reset", 32'(cpu_reset1), 32'd0);
    disp_sel = 2'd1;
    waitUntil(7);
    checkOutput("pc_display", 32'(leds), 32'h5234);
    checkOutput("dut1_second_status", 32'(leds1), 32'h4001);
    disp_sel = 2'd3;
    waitUntil(57);
    checkOutput("ce_count_idle", 32'(ce_seen), 32'd0);

    // Run: pulses every 5 cycles, first one 5 cycles after the run rise
    c = 60;
    waitUntil(c);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushPulses(c + 11, c + 126, 5);
    waitUntil(c + 8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(c + 108);
    checkOutput("status_after_20", 32'(leds), 32'h4014);
    waitUntil(c + 109);
    disp_sel = 2'd0;

    // Writes: on a ce cycle to LED address, off a ce cycle, and to another address
    waitUntil(c + 111);
    writeM = 1'b1; addressM = 15'h6001; outM = 16'hBEEF;
    waitUntil(c + 112);
    writeM = 1'b0;
    checkOutput("led_before_write", 32'(leds), 32'h0000);
    waitUntil(c + 113);
    checkOutput("led_after_write", 32'(leds), 32'hBEEF);
    writeM = 1'b1; addressM = 15'h6001; outM = 16'h1234;
    waitUntil(c + 114);
    writeM = 1'b0;
    waitUntil(c + 115);
    checkOutput("led_off_ce_write", 32'(leds), 32'hBEEF);
    waitUntil(c + 116);
    writeM = 1'b1; addressM = 15'h6000; outM = 16'hCAFE;
    waitUntil(c + 117);
    writeM = 1'b0;
    waitUntil(c + 118);
    checkOutput("led_other_addr", 32'(leds), 32'hBEEF);
    disp_sel = 2'd2;
    waitUntil(c + 119);
    checkOutput("last_wr_display", 32'(leds), 32'hCAFE);
    disp_sel = 2'd3;

    // Second run press stops the pulses
    waitUntil(c + 120);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitUntil(c + 128);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(c + 160);
    checkOutput("status_paused", 32'(leds), 32'h8018);
    checkOutput("ce_count_run", 32'(ce_seen), 32'd24);
    checkOutput("ce_queue_run", 32'(exp_ce_q.size()), 32'd0);

    // Single step with a leading 1-cycle glitch
    s = c + 170;
    waitUntil(s);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitUntil(s + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(s + 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    exp_ce_q.push_back(s + 9);
    waitUntil(s + 12);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(s + 40);
    checkOutput("ce_count_step", 32'(ce_seen), 32'd25);
    checkOutput("status_after_step", 32'(leds), 32'h8019);

    // Two-cycle bounce must not be accepted
    b = s + 50;
    waitUntil(b);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitUntil(b + 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(b + 30);
    checkOutput("ce_count_bounce", 32'(ce_seen), 32'd25);
    checkOutput("status_after_bounce", 32'(leds), 32'h8019);

    // Run and step together: run wins, no step pulse
    d = b + 40;
    e = d + 20;
    waitUntil(d);
    applyStimulus(1'b0, 1'b1, 1'b1);
    pushPulses(d + 11, e + 6, 5);
    waitUntil(d + 8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(d + 9);
    checkOutput("status_run_wins", 32'(leds), 32'h4019);

    // Core reset button mid-RUN
    waitUntil(e);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitUntil(e + 10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(e + 12);
    checkOutput("cpu_reset_hold", 32'(cpu_reset), 32'd1);
    checkOutput("cpu_ce_hold", 32'(cpu_ce), 32'd0);
    checkOutput("status_hold", 32'(leds), 32'h0000);
    disp_sel = 2'd0;
    waitUntil(e + 13);
    checkOutput("led_reg_retained", 32'(leds), 32'hBEEF);
    disp_sel = 2'd3;
    waitUntil(e + 16);
    checkOutput("cpu_reset_still_held", 32'(cpu_reset), 32'd1);
    waitUntil(e + 17);
    checkOutput("cpu_reset_leave_hold", 32'(cpu_reset), 32'd0);
    waitUntil(e + 18);
    checkOutput("status_after_hold", 32'(leds), 32'h8000);
    waitUntil(e + 40);
    checkOutput("ce_count_reset", 32'(ce_seen), 32'd29);
    checkOutput("ce_queue_reset", 32'(exp_ce_q.size()), 32'd0);

    // Counter wrap on the DIV=1 instance
    waitUntil(16389);
    checkOutput("wrap_3fff", 32'(leds1), 32'h7FFF);
    waitUntil(16390);
    checkOutput("wrap_0000", 32'(leds1), 32'h4000);
    waitUntil(16391);
    checkOutput("wrap_0001", 32'(leds1), 32'h4001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
